// File: rtl/prbs31_bist_ctrl.sv
// BIST sequencer for a PRBS31 (x^31+x^28+1) generator: seeds it, free-runs it and checks
// the looped-back stream with a self-synchronising checker, reporting error/bit counts.
module prbs31_bist_ctrl #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [30:0]      seed_i,
  input  logic [CNT_W-1:0] burst_len_i,
  input  logic             inj_err_i,
  input  logic             rx_bit_i,
  input  logic             rx_valid_i,
  output logic             gen_load_o,
  output logic [30:0]      gen_seed_o,
  output logic             gen_en_o,
  output logic             gen_inj_o,
  output logic             busy_o,
  output logic             locked_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic [CNT_W-1:0] bit_cnt_o
);

  typedef enum logic [2:0] {StIdle, StLoad, StSync, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [30:0]        sr_q, sr_d;
  logic [30:0]        gen_seed_q, gen_seed_d;
  logic [CNT_W-1:0]   burst_q, burst_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic [4:0]         sync_cnt_q, sync_cnt_d;
  logic               pass_q, pass_d;
  logic               inj_q;
  logic               gen_load_q, gen_load_d;
  logic               gen_en_q, gen_en_d;
  logic               gen_inj_q, gen_inj_d;
  logic               busy_q, busy_d;
  logic               locked_q, locked_d;
  logic               done_q, done_d;

  logic [30:0] sr_shift;
  logic        predicted;

  assign sr_shift  = {sr_q[29:0], rx_bit_i};
  assign predicted = sr_q[30] ^ sr_q[27];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      sr_q       <= '0;
      gen_seed_q <= '0;
      burst_q    <= '0;
      bit_cnt_q  <= '0;
      err_cnt_q  <= '0;
      sync_cnt_q <= '0;
      pass_q     <= 1'b0;
      inj_q      <= 1'b0;
      gen_load_q <= 1'b0;
      gen_en_q   <= 1'b0;
      gen_inj_q  <= 1'b0;
      busy_q     <= 1'b0;
      locked_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      gen_seed_q <= gen_seed_d;
      burst_q    <= burst_d;
      bit_cnt_q  <= bit_cnt_d;
      err_cnt_q  <= err_cnt_d;
      sync_cnt_q <= sync_cnt_d;
      pass_q     <= pass_d;
      inj_q      <= inj_err_i;
      gen_load_q <= gen_load_d;
      gen_en_q   <= gen_en_d;
      gen_inj_q  <= gen_inj_d;
      busy_q     <= busy_d;
      locked_q   <= locked_d;
      done_q     <= done_d;
    end
  end

  // Next-state and datapath; abort has priority and freezes the counters.
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    gen_seed_d = gen_seed_q;
    burst_d    = burst_q;
    bit_cnt_d  = bit_cnt_q;
    err_cnt_d  = err_cnt_q;
    sync_cnt_d = sync_cnt_q;
    pass_d     = pass_q;
    if (abort_i) begin
      if (state_q != StIdle) begin
        state_d = StIdle;
        pass_d  = 1'b0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_d    = StLoad;
            burst_d    = burst_len_i;
            gen_seed_d = (seed_i == '0) ? 31'h1 : seed_i;
            err_cnt_d  = '0;
            bit_cnt_d  = '0;
            sr_d       = '0;
            sync_cnt_d = '0;
            pass_d     = 1'b0;
          end
        end
        StLoad: state_d = StSync;
        StSync: begin
          if (rx_valid_i) begin
            sr_d       = sr_shift;
            sync_cnt_d = sync_cnt_q + 5'd1;
            if (sync_cnt_q == 5'd30) begin
              if (sr_shift == '0) begin
                state_d   = StDone;
                err_cnt_d = '1;
              end else if (burst_q == '0) begin
                state_d = StDone;
              end else begin
                state_d = StRun;
              end
            end
          end
        end
        StRun: begin
          if (rx_valid_i) begin
            sr_d      = sr_shift;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if ((rx_bit_i != predicted) && (err_cnt_q != '1)) begin
              err_cnt_d = err_cnt_q + 1'b1;
            end
            if (bit_cnt_d == burst_q) begin
              state_d = StDone;
            end
          end
        end
        StDone: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
    // Verdict lands together with the done pulse.
    if (state_d == StDone) begin
      pass_d = (err_cnt_d == '0);
    end
  end

  always_comb begin
    gen_load_d = (state_d == StLoad);
    gen_en_d   = (state_d == StSync) || (state_d == StRun);
    busy_d     = (state_d == StLoad) || (state_d == StSync) || (state_d == StRun);
    locked_d   = (state_d == StRun);
    done_d     = (state_d == StDone);
    gen_inj_d  = (state_q == StRun) && (state_d == StRun) && inj_err_i && !inj_q;
  end

  assign gen_load_o = gen_load_q;
  assign gen_seed_o = gen_seed_q;
  assign gen_en_o   = gen_en_q;
  assign gen_inj_o  = gen_inj_q;
  assign busy_o     = busy_q;
  assign locked_o   = locked_q;
  assign done_o     = done_q;
  assign pass_o     = pass_q;
  assign err_cnt_o  = err_cnt_q;
  assign bit_cnt_o  = bit_cnt_q;

endmodule
